dual_btn_counter: RTL
=====================

// Module: dual_btn_counter
// PURPOSE
//  Two-channel debounced push-button event counter. It feeds the two 16-bit values that the
//  8-digit seven-segment display driver renders (cnt_val_1 on digits 7..4, cnt_val_2 on 3..0).
//  Per channel: 2-FF sync -> debounce -> press detect -> 16-bit up/down wrap counter.
//  A shared clear zeroes both counters.
// PARAMETERS
//  DEBOUNCE_CYCLES  1_000_000  consecutive cycles a new synced level must hold before acceptance
//                              (10 ms at 100 MHz); legal range >= 2
//  CNT_W            16         counter width; must match display input width
// PORTS
//  clk_100MHz_i  in   1      system clock, 100 MHz
//  rst_n         in   1      asynchronous active-low reset
//  btn_1_i       in   1      raw button, channel 1; asynchronous, bouncy, active-high
//  btn_2_i       in   1      raw button, channel 2; same as btn_1_i
//  dir_1_i       in   1      channel 1 direction: 0 = count up, 1 = count down; synchronous, static
//  dir_2_i       in   1      channel 2 direction; same as dir_1_i
//  clr_i         in   1      synchronous clear of both counters, level-sensitive
//  cnt_val_1_o   out  CNT_W  channel 1 count -> display cnt_val_1_i
//  cnt_val_2_o   out  CNT_W  channel 2 count -> display cnt_val_2_i
//  evt_1_o       out  1      one-cycle pulse, registered with the cnt_val_1_o update
//  evt_2_o       out  1      one-cycle pulse for channel 2
// BEHAVIOUR
//  Reset (rst_n=0, async): sync flops, debounced level, debounce counter, cnt_val_*_o and
//   evt_*_o all go to 0. Reset mid-debounce discards the partial count.
//  Per channel, all state on posedge clk_100MHz_i:
//  - Sync: s1 <= btn_i; s2 <= s1. Only s2 is used downstream.
//  - Debounce state: deb (accepted level) and deb_cnt.
//    - deb_cnt width: $clog2(DEBOUNCE_CYCLES).
//    - s2 == deb: deb_cnt <= 0 (a glitch restarts the window).
//    - s2 != deb and deb_cnt < DEBOUNCE_CYCLES-1: deb_cnt <= deb_cnt + 1.
//    - s2 != deb and deb_cnt == DEBOUNCE_CYCLES-1: accept. deb <= s2, deb_cnt <= 0.
//  - Press = accept with s2 == 1. A release (accept with s2 == 0) updates deb only;
//    it produces no count and no evt.
//  - On a press edge:
//    - cnt <= cnt + 1 if dir=0, cnt - 1 if dir=1; modulo 2^CNT_W.
//    - Wrap cases: 0xFFFF+1 -> 0x0000, 0x0000-1 -> 0xFFFF.
//    - evt_o <= 1. On every other edge evt_o <= 0.
//  - Latency: btn_i high first sampled at edge e0 and held clean gives a new cnt value after
//    edge e0+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges in total.
//  - Holding the button gives exactly one count; auto-repeat is not supported.
//  - A button held through reset release counts once, DEBOUNCE_CYCLES+2 edges after reset.
//  clr_i == 1:
//   - Both cnt <= 0 and both evt_o <= 0.
//   - Clear wins over a simultaneous press. That press is consumed: deb still updates, so a
//     held button does not count again after clr_i falls.
//   - Debounce/sync logic keeps running during clear.
//  Channels are fully independent. Simultaneous presses on both channels each count.
//  Outputs are registered, with no combinational path from inputs.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//  1 Reset, then btn_1_i=1 held.
//    -> cnt_val_1_o 0->1 and evt_1_o=1 for exactly 1 cycle, 6 edges after first sample;
//       cnt_val_2_o stays 0.
//  2 btn_1_i glitches 1 for 3 cycles then 0, repeated 5 times -> cnt_val_1_o stays 0, no evt_1_o.
//  3 Bounce: btn_2_i toggles 1,0,1,1,0,1 then holds 1 for 20 cycles, then 0 for 20 cycles
//    -> cnt_val_2_o increments by exactly 1; the release gives no evt.
//  4 Wrap:
//    - dir_1_i=0, preload via 0xFFFF presses (or force), one press -> 0x0000.
//    - dir_1_i=1 at 0x0000, one press -> 0xFFFF.
//  5 clr_i=1 on the same edge as a channel-1 accept
//    -> cnt_val_1_o=0, evt_1_o=0; no count after clr_i drops while the button is held.
//  6 rst_n pulsed low for 1 cycle mid-debounce (deb_cnt=2)
//    -> all outputs 0 immediately (async); a held button re-counts 6 edges after release.

Source files
------------

// File: rtl/dual_btn_counter.sv
// Two-channel debounced push-button event counter.
// Each channel: 2-FF sync, debounce, press detect, up/down wrap counter.
//
// Ports (top):
//   clk_100MHz_i  system clock
//   rst_n         asynchronous active-low reset
//   btn_1_i/2_i   raw bouncy buttons, active-high
//   dir_1_i/2_i   count direction, 0 = up, 1 = down
//   clr_i         synchronous clear of both counters
//   cnt_val_*_o   per-channel count
//   evt_*_o       one-cycle pulse with each count update

module dual_btn_counter_ch #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    input  logic             dir,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             evt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // Synchroniser: only s2 is trusted downstream.
    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Debounce: a new level must hold for DEBOUNCE_CYCLES
    // consecutive samples; any return to the old level
    // restarts the window.
    logic          deb;
    logic [DW-1:0] deb_cnt;
    logic          differ;
    logic          accept;
    logic          press;

    assign differ = (s2 != deb);
    assign accept = differ && (deb_cnt == DEB_LAST);
    assign press  = accept && s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb     <= 1'b0;
            deb_cnt <= '0;
        end else if (!differ) begin
            deb_cnt <= '0;
        end else if (accept) begin
            deb     <= s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // Counter. Clear takes priority and swallows a coincident
    // press; the debouncer still accepts it, so a held button
    // does not count again once clear is released.
    logic [CNT_W-1:0] next_cnt;

    assign next_cnt = dir ? (cnt - ONE) : (cnt + ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            evt <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            evt <= 1'b0;
        end else if (press) begin
            cnt <= next_cnt;
            evt <= 1'b1;
        end else begin
            evt <= 1'b0;
        end
    end

endmodule

module dual_btn_counter #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk_100MHz_i,
    input  logic             rst_n,
    input  logic             btn_1_i,
    input  logic             btn_2_i,
    input  logic             dir_1_i,
    input  logic             dir_2_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_val_1_o,
    output logic [CNT_W-1:0] cnt_val_2_o,
    output logic             evt_1_o,
    output logic             evt_2_o
);

    dual_btn_counter_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch1 (
        .clk   (clk_100MHz_i),
        .rst_n (rst_n),
        .btn   (btn_1_i),
        .dir   (dir_1_i),
        .clr   (clr_i),
        .cnt   (cnt_val_1_o),
        .evt   (evt_1_o)
    );

    dual_btn_counter_ch #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_ch2 (
        .clk   (clk_100MHz_i),
        .rst_n (rst_n),
        .btn   (btn_2_i),
        .dir   (dir_2_i),
        .clr   (clr_i),
        .cnt   (cnt_val_2_o),
        .evt   (evt_2_o)
    );

endmodule
